// File: rtl/pwm_multi.sv
// Multi-channel PWM peripheral: shared prescaler, double-buffered period/duty per channel,
// sticky per-channel wrap flags with a maskable level interrupt.
module pwm_multi #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned CNT_W  = 32,
   parameter int unsigned PRE_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we_i,
   input  logic [31:0]       addr_i,
   input  logic [31:0]       data_i,
   output logic [31:0]       data_o,
   output logic [NUM_CH-1:0] pw_pin,
   output logic              irq_o
);

   logic [CNT_W-1:0]  period_q [NUM_CH];
   logic [CNT_W-1:0]  period_d [NUM_CH];
   logic [CNT_W-1:0]  duty_q   [NUM_CH];
   logic [CNT_W-1:0]  duty_d   [NUM_CH];
   logic [CNT_W-1:0]  cnt_q    [NUM_CH];
   logic [CNT_W-1:0]  cnt_d    [NUM_CH];
   logic [CNT_W-1:0]  per_s_q  [NUM_CH];
   logic [CNT_W-1:0]  per_s_d  [NUM_CH];
   logic [CNT_W-1:0]  duty_s_q [NUM_CH];
   logic [CNT_W-1:0]  duty_s_d [NUM_CH];
   logic [NUM_CH-1:0] ctrl_q, ctrl_d, pol_q, pol_d, status_q, status_d;
   logic [NUM_CH-1:0] irq_en_q, irq_en_d, pin_q, pin_d;
   logic [PRE_W-1:0]  presc_q, presc_d, pre_q, pre_d;
   logic              tick;

   logic [7:0] idx;
   logic [3:0] ch_sel;
   logic       ch_ok;
   logic       sel_period, sel_duty, sel_ctrl, sel_pol, sel_presc, sel_status, sel_irq_en;

   assign idx        = addr_i[23:16];
   assign ch_sel     = idx[3:0];
   assign ch_ok      = ({1'b0, ch_sel} < 5'(NUM_CH));
   assign sel_period = (idx[7:4] == 4'h0) && ch_ok;
   assign sel_duty   = (idx[7:4] == 4'h1) && ch_ok;
   assign sel_ctrl   = (idx == 8'h20);
   assign sel_pol    = (idx == 8'h21);
   assign sel_presc  = (idx == 8'h22);
   assign sel_status = (idx == 8'h23);
   assign sel_irq_en = (idx == 8'h24);

   assign tick   = (pre_q == presc_q);
   assign pw_pin = pin_q;
   assign irq_o  = |(status_q & irq_en_q);

   always_comb begin
      data_o = '0;
      if (rst) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel_period && ch_sel == 4'(c)) data_o = 32'(period_q[c]);
            if (sel_duty && ch_sel == 4'(c))   data_o = 32'(duty_q[c]);
         end
         if (sel_ctrl)   data_o = 32'(ctrl_q);
         if (sel_pol)    data_o = 32'(pol_q);
         if (sel_presc)  data_o = 32'(presc_q);
         if (sel_status) data_o = 32'(status_q);
         if (sel_irq_en) data_o = 32'(irq_en_q);
      end
   end

   always_comb begin
      period_d = period_q;
      duty_d   = duty_q;
      cnt_d    = cnt_q;
      per_s_d  = per_s_q;
      duty_s_d = duty_s_q;
      ctrl_d   = ctrl_q;
      pol_d    = pol_q;
      presc_d  = presc_q;
      status_d = status_q;
      irq_en_d = irq_en_q;
      pin_d    = pin_q;
      pre_d    = tick ? '0 : pre_q + 1'b1;

      if (we_i) begin
         for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (sel_period && ch_sel == 4'(c)) period_d[c] = data_i[CNT_W-1:0];
            if (sel_duty && ch_sel == 4'(c))   duty_d[c]   = data_i[CNT_W-1:0];
         end
         if (sel_ctrl)   ctrl_d   = data_i[NUM_CH-1:0];
         if (sel_pol)    pol_d    = data_i[NUM_CH-1:0];
         if (sel_irq_en) irq_en_d = data_i[NUM_CH-1:0];
         if (sel_status) status_d = status_q & ~data_i[NUM_CH-1:0];
         if (sel_presc) begin
            presc_d = data_i[PRE_W-1:0];
            pre_d   = '0;
         end
      end

      // Wrap sets are applied after the W1C clear so a coincident set wins.
      for (int unsigned c = 0; c < NUM_CH; c++) begin
         if (!ctrl_q[c]) begin
            cnt_d[c]    = '0;
            per_s_d[c]  = period_q[c];
            duty_s_d[c] = duty_q[c];
            pin_d[c]    = pol_q[c];
         end else begin
            pin_d[c] = (cnt_q[c] < duty_s_q[c]) ^ pol_q[c];
            if (tick) begin
               if (cnt_q[c] >= per_s_q[c]) begin
                  cnt_d[c]    = '0;
                  per_s_d[c]  = period_q[c];
                  duty_s_d[c] = duty_q[c];
                  status_d[c] = 1'b1;
               end else begin
                  cnt_d[c] = cnt_q[c] + 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         period_q <= '{default: '0};
         duty_q   <= '{default: '0};
         cnt_q    <= '{default: '0};
         per_s_q  <= '{default: '0};
         duty_s_q <= '{default: '0};
         ctrl_q   <= '0;
         pol_q    <= '0;
         presc_q  <= '0;
         status_q <= '0;
         irq_en_q <= '0;
         pin_q    <= '0;
         pre_q    <= '0;
      end else begin
         period_q <= period_d;
         duty_q   <= duty_d;
         cnt_q    <= cnt_d;
         per_s_q  <= per_s_d;
         duty_s_q <= duty_s_d;
         ctrl_q   <= ctrl_d;
         pol_q    <= pol_d;
         presc_q  <= presc_d;
         status_q <= status_d;
         irq_en_q <= irq_en_d;
         pin_q    <= pin_d;
         pre_q    <= pre_d;
      end
   end

endmodule

// File: tb/tb_pwm_multi.sv
// Directed bench for pwm_multi (4 channels, 8-bit counters): registers, waveform,
// prescaler/polarity, shadow update, duty extremes, interrupt and asynchronous reset.
module tb_pwm_multi;

   logic        clk = 1'b0;
   logic        rst;
   logic        we_i;
   logic [31:0] addr_i;
   logic [31:0] data_i;
   logic [31:0] data_o;
   logic [3:0]  pw_pin;
   logic        irq_o;

   int n_cmp = 0;
   int n_err = 0;

   pwm_multi #(
      .NUM_CH (4),
      .CNT_W  (8),
      .PRE_W  (16)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .we_i   (we_i),
      .addr_i (addr_i),
      .data_i (data_i),
      .data_o (data_o),
      .pw_pin (pw_pin),
      .irq_o  (irq_o)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] a(input logic [7:0] idx);
      return {8'h00, idx, 16'h0000};
   endfunction

   task automatic wr(input logic [7:0] idx, input logic [31:0] d);
      addr_i = a(idx);
      data_i = d;
      we_i   = 1'b1;
      @(posedge clk);
      #1;
      we_i   = 1'b0;
   endtask

   task automatic rd(input logic [31:0] adr, output logic [31:0] d);
      addr_i = adr;
      #1;
      d = data_o;
   endtask

   task automatic test_reset;
      logic [31:0] d;
      rst = 1'b1; we_i = 1'b0; addr_i = a(8'h23); data_i = '0;
      #2 rst = 1'b0;
      #3;
      n_cmp++; if (pw_pin !== 4'h0) begin n_err++; $display("FAIL rst_pins: got %h want 0", pw_pin); end
      n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL rst_irq: got %b want 0", irq_o); end
      n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h want 0", data_o); end
      #7 rst = 1'b1;
      @(posedge clk); #1;
      wr(8'h00, 32'hFFFF_FFFF);
      rd(a(8'h00), d);
      n_cmp++; if (d !== 32'h0000_00FF) begin n_err++; $display("FAIL trunc_period: got %h want 000000ff", d); end
      wr(8'h12, 32'h0000_1234);
      rd(a(8'h12), d);
      n_cmp++; if (d !== 32'h0000_0034) begin n_err++; $display("FAIL trunc_duty2: got %h want 00000034", d); end
      wr(8'h21, 32'hFFFF_FFFF);
      rd(a(8'h21), d);
      n_cmp++; if (d !== 32'h0000_000F) begin n_err++; $display("FAIL pol_width: got %h want 0000000f", d); end
      wr(8'h22, 32'hABCD_EF12);
      rd({8'h5A, 8'h22, 16'hFFFF}, d);
      n_cmp++; if (d !== 32'h0000_EF12) begin n_err++; $display("FAIL presc_decode: got %h want 0000ef12", d); end
      wr(8'h25, 32'hFFFF_FFFF);
      rd(a(8'h25), d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL unmapped: got %h want 0", d); end
      wr(8'h04, 32'h55);
      rd(a(8'h04), d);
      n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL no_ch4: got %h want 0", d); end
      wr(8'h21, 32'h0);
      wr(8'h22, 32'h0);
   endtask

   task automatic test_basic;
      logic e;
      wr(8'h00, 32'd3);
      wr(8'h10, 32'd2);
      wr(8'h23, 32'hF);
      wr(8'h20, 32'h1);
      addr_i = a(8'h23);
      for (int k = 1; k <= 12; k++) begin
         @(posedge clk); #1;
         e = ((k - 1) % 4 < 2);
         n_cmp++; if (pw_pin[0] !== e) begin n_err++; $display("FAIL basic_pin k=%0d: got %b want %b", k, pw_pin[0], e); end
         if (k == 3 || k == 4) begin
            e = (k >= 4);
            n_cmp++; if (data_o[0] !== e) begin n_err++; $display("FAIL basic_status k=%0d: got %b want %b", k, data_o[0], e); end
         end
      end
      wr(8'h20, 32'h0);
      n_cmp++; if (pw_pin[0] !== 1'b1) begin n_err++; $display("FAIL disable_edge: got %b want 1", pw_pin[0]); end
      @(posedge clk); #1;
      n_cmp++; if (pw_pin[0] !== 1'b0) begin n_err++; $display("FAIL disable_pin: got %b want 0", pw_pin[0]); end
      wr(8'h23, 32'hF);
   endtask

   task automatic test_presc_pol;
      logic e;
      wr(8'h00, 32'd4);
      wr(8'h10, 32'd1);
      wr(8'h21, 32'h1);
      wr(8'h22, 32'd2);
      wr(8'h20, 32'h1);
      for (int k = 1; k <= 44; k++) begin
         @(posedge clk); #1;
         if (k <= 2)       e = 1'b0;
         else if (k <= 14) e = 1'b1;
         else              e = ((k - 15) % 15 >= 3);
         n_cmp++; if (pw_pin[0] !== e) begin n_err++; $display("FAIL presc_pin k=%0d: got %b want %b", k, pw_pin[0], e); end
      end
      wr(8'h20, 32'h0);
      wr(8'h21, 32'h0);
      wr(8'h22, 32'h0);
      wr(8'h23, 32'hF);
   endtask

   task automatic test_glitch_free;
      logic e;
      wr(8'h00, 32'd9);
      wr(8'h10, 32'd5);
      wr(8'h20, 32'h1);
      for (int k = 1; k <= 20; k++) begin
         if (k == 4) begin addr_i = a(8'h00); data_i = 32'd1; we_i = 1'b1; end
         if (k == 5) begin addr_i = a(8'h10); data_i = 32'd1; we_i = 1'b1; end
         @(posedge clk); #1;
         we_i = 1'b0;
         if (k <= 5)       e = 1'b1;
         else if (k <= 10) e = 1'b0;
         else              e = (k % 2 == 1);
         n_cmp++; if (pw_pin[0] !== e) begin n_err++; $display("FAIL glitch_pin k=%0d: got %b want %b", k, pw_pin[0], e); end
      end
      wr(8'h20, 32'h0);
      wr(8'h23, 32'hF);
   endtask

   task automatic test_duty_extremes;
      logic [1:0] e;
      wr(8'h00, 32'd3);
      wr(8'h10, 32'd0);
      wr(8'h01, 32'd3);
      wr(8'h11, 32'd8);
      wr(8'h20, 32'h3);
      addr_i = a(8'h23);
      for (int k = 1; k <= 8; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (pw_pin[1:0] !== 2'b10) begin n_err++; $display("FAIL extreme_pins k=%0d: got %b want 10", k, pw_pin[1:0]); end
         if (k == 3 || k == 4) begin
            e = (k == 4) ? 2'b11 : 2'b00;
            n_cmp++; if (data_o[1:0] !== e) begin n_err++; $display("FAIL extreme_status k=%0d: got %b want %b", k, data_o[1:0], e); end
         end
      end
      wr(8'h20, 32'h0);
      wr(8'h23, 32'hF);
   endtask

   task automatic test_irq;
      logic e;
      wr(8'h24, 32'h2);
      wr(8'h00, 32'd1);
      wr(8'h10, 32'd1);
      wr(8'h01, 32'd4);
      wr(8'h11, 32'd1);
      wr(8'h20, 32'h3);
      addr_i = a(8'h23);
      data_i = 32'h2;
      for (int k = 1; k <= 15; k++) begin
         if (k == 10 || k == 11) we_i = 1'b1;
         @(posedge clk); #1;
         we_i = 1'b0;
         if (k < 5)       e = 1'b0;
         else if (k <= 10) e = 1'b1;
         else             e = (k == 15);
         n_cmp++; if (irq_o !== e) begin n_err++; $display("FAIL irq k=%0d: got %b want %b", k, irq_o, e); end
         if (k == 12) begin
            n_cmp++; if (data_o[1:0] !== 2'b01) begin n_err++; $display("FAIL irq_status: got %b want 01", data_o[1:0]); end
         end
      end
   endtask

   task automatic test_reset_mid;
      logic [31:0] d;
      logic [7:0]  regs [13] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h10, 8'h11, 8'h12, 8'h13,
                                 8'h20, 8'h21, 8'h22, 8'h23, 8'h24};
      addr_i = a(8'h23);
      #3 rst = 1'b0;
      #1;
      n_cmp++; if (pw_pin !== 4'h0) begin n_err++; $display("FAIL mid_rst_pins: got %h want 0", pw_pin); end
      n_cmp++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL mid_rst_irq: got %b want 0", irq_o); end
      n_cmp++; if (data_o !== 32'h0) begin n_err++; $display("FAIL mid_rst_data: got %h want 0", data_o); end
      @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 13; i++) begin
         rd(a(regs[i]), d);
         n_cmp++; if (d !== 32'h0) begin n_err++; $display("FAIL post_rst_reg %h: got %h want 0", regs[i], d); end
      end
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         n_cmp++; if (pw_pin !== 4'h0) begin n_err++; $display("FAIL post_rst_pins k=%0d: got %h want 0", k, pw_pin); end
      end
   endtask

   initial begin
      test_reset;
      test_basic;
      test_presc_pol;
      test_glitch_free;
      test_duty_extremes;
      test_irq;
      test_reset_mid;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pwm_multi.md
# pwm_multi

Parametrised multi-channel PWM peripheral on the core's memory-mapped peripheral bus, succeeding the fixed 4-channel PWM. It provides NUM_CH independent channels, each with its own period, duty, enable and output polarity. A shared programmable prescaler drives all channels. Period and duty are double-buffered so reprogramming never produces a glitch. Each channel has a sticky period-end status flag, and the flags can raise a maskable interrupt.

## Interface

Parameters:
- NUM_CH, 4: number of channels, 1..16.
- CNT_W, 32: width of the period/duty counters, 8..32.
- PRE_W, 16: width of the prescaler, 1..32.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- rst  input  1  asynchronous, active-low reset.
- we_i  input  1  write strobe, sampled on the rising clk edge.
- addr_i  input  32  address; only addr_i[23:16] selects a register.
- data_i  input  32  write data.
- data_o  output  32  read data, combinational from addr_i; 0 while rst is low.
- pw_pin  output  NUM_CH  registered PWM outputs, one bit per channel.
- irq_o  output  1  level interrupt, equal to |(STATUS & IRQ_EN).

## Operation

Register map, indexed by addr_i[23:16], ch = 0..NUM_CH-1:
- 0x00+ch  PERIOD[ch] (CNT_W bits, R/W). The channel period is PERIOD+1 ticks.
- 0x10+ch  DUTY[ch] (CNT_W bits, R/W). The output is active for DUTY ticks per period.
- 0x20  CTRL (R/W). Bit ch is the channel ch enable.
- 0x21  POL (R/W). Bit ch = 1 inverts pin ch.
- 0x22  PRESC (PRE_W bits, R/W). Any write also clears the prescaler counter.
- 0x23  STATUS (R/W1C). Bit ch is the sticky wrap flag for channel ch.
- 0x24  IRQ_EN (R/W). Per-channel interrupt mask.

Register access:
- Writes store data_i truncated to the register width.
- Reads return the value zero-extended to 32 bits.
- Unmapped addresses: reads return 0 and writes are ignored.

Prescaler:
- The prescaler counter pre runs freely out of reset.
- If pre == PRESC, then pre <= 0 and tick = 1 for that cycle; otherwise pre <= pre + 1.
- With PRESC = 0, tick = 1 every cycle.

Per channel, registers cnt, per_s and duty_s:
- When enable = 0: cnt <= 0, per_s <= PERIOD, duty_s <= DUTY, and pin <= POL. The shadows track the programmed values continuously.
- When enable = 1 and tick = 1:
  - If cnt >= per_s: cnt <= 0, per_s <= PERIOD, duty_s <= DUTY, and STATUS[ch] is set.
  - Otherwise: cnt <= cnt + 1.
- When enable = 1 and tick = 0: cnt holds.
- When enable = 1: pin <= (cnt < duty_s) ^ POL on every clk, whether or not a tick occurs.
- DUTY = 0 gives a constant inactive output (POL).
- DUTY > PERIOD gives a constant active output (~POL).
- Writes to PERIOD or DUTY while enabled take effect only at the next wrap. The current period always completes with the old values, including when the new PERIOD is below the current cnt.

Status and interrupt:
- Writing STATUS clears every bit that is 1 in data_i.
- If a wrap set and a W1C clear hit the same bit in the same cycle, the set wins.

## Timing

- Reset (async, rst = 0) immediately clears all registers, cnt, pre and shadows.
  - Resulting outputs: pw_pin = 0, irq_o = 0, data_o = 0.
  - A reset in mid-period abandons that period; after release every channel is disabled.
- Register writes take effect at the clk edge where we_i = 1. data_o has zero latency.
- Pin latency: pw_pin reflects the cnt value from one cycle earlier.
  - Example: PRESC = 0, PERIOD = 3, DUTY = 2, POL = 0, enable written at edge E0.
  - Edges E1 and E2: pin = 1. Edges E3 and E4: pin = 0. The pattern repeats every 4 cycles.
  - STATUS[ch] sets at E4, and irq_o rises in the same cycle if unmasked.
- Disable mid-period: at the next edge cnt = 0 and pin = POL. Re-enabling starts a fresh period from cnt = 0.
- Channels with equal settings enabled in the same write stay phase-aligned.
- Counter arithmetic is CNT_W bits. cnt never exceeds per_s, so it cannot wrap past 2^CNT_W − 1.
- PERIOD = 2^CNT_W − 1 is legal.

## Test plan

1. Reset and registers: rst low mid-operation. Pins, irq_o and data_o go to 0 asynchronously, and all registers read 0 after release. Writing 0xFFFFFFFF to PERIOD[0] with CNT_W = 8 reads back 0x000000FF.
2. Basic waveform: PRESC = 0, PERIOD[0] = 3, DUTY[0] = 2, CTRL = 1. pw_pin[0] is 1 for 2 cycles and 0 for 2 cycles, starting the cycle after enable. STATUS[0] sets every 4 cycles.
3. Prescaler and polarity: PRESC = 2, PERIOD = 4, DUTY = 1, POL = 1. The period is 15 cycles, with pin low for 3 and high for 12.
4. Glitch-free update: while cnt = 3 with PERIOD = 9, write PERIOD = 1 and DUTY = 1. The current period completes 10 ticks; from the next wrap the output is 1 tick high, 1 tick low.
5. Duty extremes: DUTY = 0 gives a constant 0. DUTY = PERIOD + 5 gives a constant 1. STATUS still sets on each wrap.
6. Interrupt: IRQ_EN = 0x2 with channels 0 and 1 running; irq_o rises only on the channel 1 wrap. A W1C of 0x2 in the same cycle as a channel 1 wrap leaves STATUS[1] = 1. A later W1C of 0x2 drops irq_o.
